// File: rtl/bsg_mem_1r1w_wr_sched.sv
// Write-port scheduler for a 1r1w register file.
// Round-robin arbitration, read-collision blocking, post-reset clear.
module bsg_mem_1r1w_wr_sched #(
  parameter int width_p = 8,
  parameter int els_p = 8,
  parameter int num_req_p = 2,
  parameter bit read_write_same_addr_p = 1'b0,
  parameter bit init_p = 1'b1,
  parameter logic [width_p-1:0] init_val_p = '0,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic [num_req_p-1:0] v_i,
  input  logic [num_req_p*addr_width_lp-1:0] addr_i,
  input  logic [num_req_p*width_p-1:0] data_i,
  output logic [num_req_p-1:0] ready_o,
  input  logic r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic mem_w_v_o,
  output logic [addr_width_lp-1:0] mem_w_addr_o,
  output logic [width_p-1:0] mem_w_data_o,
  output logic init_done_o,
  output logic err_o
);

  localparam int rr_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam logic [addr_width_lp-1:0] last_lp =
    addr_width_lp'(els_p - 1);
  localparam logic [addr_width_lp:0] els_lp =
    (addr_width_lp+1)'(els_p);
  localparam logic [rr_w_lp-1:0] top_lp =
    rr_w_lp'(num_req_p - 1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e r_state, w_state_n;
  logic [addr_width_lp-1:0] r_init_cnt, w_init_cnt_n;
  logic [rr_w_lp-1:0] r_rr, w_rr_n;
  logic r_err, w_err_n;

  logic [num_req_p-1:0] w_elig;
  logic w_found;
  logic [rr_w_lp-1:0] w_win;
  logic [addr_width_lp-1:0] w_win_addr;
  logic [width_p-1:0] w_win_data;
  logic w_in_range;

  // A requester is eligible unless it collides with the live read.
  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      w_elig[i] = v_i[i] & ~(~read_write_same_addr_p & r_v_i &
        (addr_i[i*addr_width_lp +: addr_width_lp] == r_addr_i));
    end
  end

  // Rotating priority: scan rr..top first, then wrap to 0..rr-1.
  always_comb begin
    w_found = 1'b0;
    w_win = '0;
    w_win_addr = '0;
    w_win_data = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!w_found && w_elig[i] && (i >= int'(r_rr))) begin
        w_found = 1'b1;
        w_win = rr_w_lp'(i);
        w_win_addr = addr_i[i*addr_width_lp +: addr_width_lp];
        w_win_data = data_i[i*width_p +: width_p];
      end
    end
    for (int i = 0; i < num_req_p; i++) begin
      if (!w_found && w_elig[i]) begin
        w_found = 1'b1;
        w_win = rr_w_lp'(i);
        w_win_addr = addr_i[i*addr_width_lp +: addr_width_lp];
        w_win_data = data_i[i*width_p +: width_p];
      end
    end
  end

  assign w_in_range = ({1'b0, w_win_addr} < els_lp);

  // Next state and write-port drive; reset forces handshakes low.
  always_comb begin
    w_state_n = r_state;
    w_init_cnt_n = r_init_cnt;
    w_rr_n = r_rr;
    w_err_n = 1'b0;
    ready_o = '0;
    mem_w_v_o = 1'b0;
    mem_w_addr_o = w_win_addr;
    mem_w_data_o = w_win_data;
    init_done_o = 1'b0;
    unique case (r_state)
      S_INIT: begin
        mem_w_v_o = 1'b1;
        mem_w_addr_o = r_init_cnt;
        mem_w_data_o = init_val_p;
        w_init_cnt_n = r_init_cnt + 1'b1;
        if (r_init_cnt == last_lp) w_state_n = S_RUN;
      end
      S_RUN: begin
        init_done_o = 1'b1;
        for (int i = 0; i < num_req_p; i++) begin
          ready_o[i] = w_found & (w_win == rr_w_lp'(i));
        end
        mem_w_v_o = w_found & w_in_range;
        w_err_n = w_found & ~w_in_range;
        if (w_found) begin
          w_rr_n = (w_win == top_lp) ? '0 : w_win + 1'b1;
        end
      end
      default: ;
    endcase
    if (!reset_n_i) begin
      ready_o = '0;
      mem_w_v_o = 1'b0;
      init_done_o = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= init_p ? S_INIT : S_RUN;
      r_init_cnt <= '0;
      r_rr <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_init_cnt <= w_init_cnt_n;
      r_rr <= w_rr_n;
      r_err <= w_err_n;
    end
  end

  assign err_o = r_err;

endmodule
